bcd_accumulator: RTL and testbench

- Parametrised N-digit BCD accumulator register for score and counter displays.
- Accepts a signed per-digit delta (-9..+9) at a selectable digit position.
- Ripples the decimal carry/borrow upward one digit per clock; out-of-range results saturate at 0 or all-9s.
- Sits between game/control logic and the seven-segment drivers.

---
 rtl/bcd_accumulator.sv | 118 +++++++++++
 tb/tb_bcd_accumulator.sv | 178 +++++++++++++++++
 2 files changed

// File: rtl/bcd_accumulator.sv
// rtl/bcd_accumulator.sv - N-digit BCD accumulator with rippled decimal carry/borrow
// Optional build macro BCD_ACC_WRAP_EN: terminal carry wraps modulo 10^DIGITS instead of saturating.
module bcd_accumulator #(
    parameter int DIGITS = 4,
    localparam int PW = ($clog2(DIGITS) < 1) ? 1 : $clog2(DIGITS)
) (
    input  logic                clk,
    input  logic                reset,
    input  logic                load,
    input  logic [4*DIGITS-1:0] load_value,
    input  logic                in_valid,
    input  logic [4:0]          delta,
    input  logic [PW-1:0]       pos,
    output logic                in_ready,
    output logic [4*DIGITS-1:0] value,
    output logic                done,
    output logic                overflow,
    output logic                underflow,
    output logic                err
);

    typedef enum logic {IDLE, RIPPLE} state_t;

    state_t              state;
    logic [PW-1:0]       cursor;
    logic                carry_neg;

    int                  sel_i;
    logic [4:0]          addend;
    logic [3:0]          digit;
    logic signed [5:0]   s;
    logic                step_up;
    logic                step_dn;
    logic [3:0]          new_digit;
    logic [4*DIGITS-1:0] stepped;
    logic [4*DIGITS-1:0] load_sat;
    logic                terminal;
    logic                delta_ok;
    logic                pos_ok;
    logic                go;

    assign in_ready = (state == IDLE);

    // One digit adder shared by the accepting edge (delta at pos) and every ripple cycle (carry at cursor).
    always_comb begin
        sel_i = 0;
        if (state == RIPPLE)
            sel_i = int'(cursor);
        else if (int'(pos) < DIGITS)
            sel_i = int'(pos);
        addend    = (state == RIPPLE) ? (carry_neg ? 5'b11111 : 5'b00001) : delta;
        digit     = value[4*sel_i +: 4];
        s         = $signed({2'b00, digit}) + $signed({addend[4], addend});
        step_up   = (s > 6'sd9);
        step_dn   = (s < 6'sd0);
        // Modulo-16 arithmetic on the low nibble gives the exact +/-10 correction for s in -9..18.
        if (step_dn)
            new_digit = s[3:0] + 4'd10;
        else if (step_up)
            new_digit = s[3:0] - 4'd10;
        else
            new_digit = s[3:0];
        stepped = value;
        stepped[4*sel_i +: 4] = new_digit;
        terminal = (step_up || step_dn) && (sel_i == DIGITS - 1);
        delta_ok = ($signed(delta) >= -5'sd9) && ($signed(delta) <= 5'sd9);
        pos_ok   = (int'(pos) < DIGITS);
        go = (state == RIPPLE) || (!load && in_valid && delta_ok && pos_ok);
        for (int i = 0; i < DIGITS; i++)
            load_sat[4*i +: 4] = (load_value[4*i +: 4] > 4'd9) ? 4'd9 : load_value[4*i +: 4];
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state     <= IDLE;
            value     <= '0;
            cursor    <= '0;
            carry_neg <= 1'b0;
            done      <= 1'b0;
            overflow  <= 1'b0;
            underflow <= 1'b0;
            err       <= 1'b0;
        end else begin
            done      <= 1'b0;
            overflow  <= 1'b0;
            underflow <= 1'b0;
            err       <= 1'b0;
            if (state == IDLE && load) begin
                value <= load_sat;
                done  <= 1'b1;
            end else if (state == IDLE && in_valid && !(delta_ok && pos_ok)) begin
                err <= 1'b1;
            end else if (go) begin
                if (terminal) begin
`ifdef BCD_ACC_WRAP_EN
                    value <= stepped;
`else
                    value <= step_up ? {DIGITS{4'h9}} : '0;
`endif
                    overflow  <= step_up;
                    underflow <= step_dn;
                    done      <= 1'b1;
                    state     <= IDLE;
                end else if (step_up || step_dn) begin
                    value     <= stepped;
                    cursor    <= PW'(sel_i + 1);
                    carry_neg <= step_dn;
                    state     <= RIPPLE;
                end else begin
                    value <= stepped;
                    done  <= 1'b1;
                    state <= IDLE;
                end
            end
        end
    end

endmodule

// File: tb/tb_bcd_accumulator.sv
// tb/tb_bcd_accumulator.sv - scoreboard bench for bcd_accumulator with DIGITS=4
module tb_bcd_accumulator;

    logic        clk = 1'b0;
    logic        reset = 1'b0;
    logic        load = 1'b0;
    logic [15:0] load_value = '0;
    logic        in_valid = 1'b0;
    logic [4:0]  delta = '0;
    logic [1:0]  pos = '0;
    logic        in_ready;
    logic [15:0] value;
    logic        done;
    logic        overflow;
    logic        underflow;
    logic        err;

    bcd_accumulator #(.DIGITS(4)) dut (
        .clk(clk), .reset(reset), .load(load), .load_value(load_value),
        .in_valid(in_valid), .delta(delta), .pos(pos), .in_ready(in_ready),
        .value(value), .done(done), .overflow(overflow), .underflow(underflow), .err(err)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [15:0] v;
        logic        o;
        logic        u;
        logic        e;
        int          k;
        int          t;
    } exp_t;

    exp_t sb[$];
    int   n_cmp = 0;
    int   n_bad = 0;
    int   cyc = 0;
    logic mon_en = 1'b0;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string name, input int act, input int req);
        n_cmp++;
        if (act != req) begin
            n_bad++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, req);
        end
    endtask

    // Monitor: every done/err pulse consumes one expected response.
    always @(negedge clk) begin
        if (mon_en && (done === 1'b1 || err === 1'b1)) begin
            if (sb.size() == 0) begin
                chk("unexpected_response", 1, 0);
            end else begin
                exp_t x;
                x = sb.pop_front();
                chk("value", int'(value), int'(x.v));
                chk("done", int'(done), int'(!x.e));
                chk("err", int'(err), int'(x.e));
                chk("overflow", int'(overflow), int'(x.o));
                chk("underflow", int'(underflow), int'(x.u));
                chk("latency", cyc - x.t, x.k);
            end
        end
    end

    task automatic op(input logic ld, input logic [15:0] lv, input logic vld,
                      input logic [4:0] d, input logic [1:0] p,
                      input logic [15:0] ev, input logic eo, input logic eu,
                      input logic ee, input int k);
        int n;
        @(negedge clk);
        n = 0;
        while (!in_ready && n < 50) begin
            @(negedge clk);
            n++;
        end
        load = ld; load_value = lv; in_valid = vld; delta = d; pos = p;
        @(posedge clk);
        #1;
        load = 1'b0; in_valid = 1'b0;
        sb.push_back('{v: ev, o: eo, u: eu, e: ee, k: k, t: cyc});
        n = 0;
        while (n < 50) begin
            @(negedge clk);
            if (in_ready) break;
            n++;
        end
        chk("ready_low_cycles", n, k);
        n = 0;
        while (sb.size() != 0 && n < 50) begin
            @(negedge clk);
            n++;
        end
        if (sb.size() != 0) begin
            chk("response_timeout", 1, 0);
            sb.delete();
        end
    endtask

    initial begin
        reset = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        reset = 1'b0;
        @(negedge clk);
        chk("reset_value", int'(value), 0);
        chk("reset_ready", int'(in_ready), 1);
        chk("reset_flags", int'({done, overflow, underflow, err}), 0);
        mon_en = 1'b1;

        op(0, 16'h0000, 1, 5'd7, 2'd0, 16'h0007, 0, 0, 0, 0);
        op(1, 16'h0999, 0, 5'd0, 2'd0, 16'h0999, 0, 0, 0, 0);
        op(0, 16'h0000, 1, 5'd1, 2'd0, 16'h1000, 0, 0, 0, 3);
        op(1, 16'h1000, 0, 5'd0, 2'd0, 16'h1000, 0, 0, 0, 0);
        op(0, 16'h0000, 1, 5'h1f, 2'd0, 16'h0999, 0, 0, 0, 3);
        op(1, 16'h9999, 0, 5'd0, 2'd0, 16'h9999, 0, 0, 0, 0);
`ifdef BCD_ACC_WRAP_EN
        op(0, 16'h0000, 1, 5'd1, 2'd0, 16'h0000, 1, 0, 0, 3);
`else
        op(0, 16'h0000, 1, 5'd1, 2'd0, 16'h9999, 1, 0, 0, 3);
`endif
        op(1, 16'h0002, 0, 5'd0, 2'd0, 16'h0002, 0, 0, 0, 0);
`ifdef BCD_ACC_WRAP_EN
        op(0, 16'h0000, 1, 5'h1d, 2'd0, 16'h9999, 0, 1, 0, 3);
        op(0, 16'h0000, 1, 5'b01100, 2'd0, 16'h9999, 0, 0, 1, 0);
        op(0, 16'h0000, 1, 5'b10110, 2'd1, 16'h9999, 0, 0, 1, 0);
`else
        op(0, 16'h0000, 1, 5'h1d, 2'd0, 16'h0000, 0, 1, 0, 3);
        op(0, 16'h0000, 1, 5'b01100, 2'd0, 16'h0000, 0, 0, 1, 0);
        op(0, 16'h0000, 1, 5'b10110, 2'd1, 16'h0000, 0, 0, 1, 0);
`endif
        op(1, 16'h00A5, 0, 5'd0, 2'd0, 16'h0095, 0, 0, 0, 0);
        op(0, 16'h0000, 1, 5'd9, 2'd1, 16'h0185, 0, 0, 0, 1);
`ifdef BCD_ACC_WRAP_EN
        op(0, 16'h0000, 1, 5'b10111, 2'd2, 16'h9285, 0, 1, 0, 1);
`else
        op(0, 16'h0000, 1, 5'b10111, 2'd2, 16'h0000, 0, 1, 0, 1);
`endif
        op(1, 16'h7000, 0, 5'd0, 2'd0, 16'h7000, 0, 0, 0, 0);
`ifdef BCD_ACC_WRAP_EN
        op(0, 16'h0000, 1, 5'd5, 2'd3, 16'h2000, 1, 0, 0, 0);
`else
        op(0, 16'h0000, 1, 5'd5, 2'd3, 16'h9999, 1, 0, 0, 0);
`endif
        // load has priority over a simultaneous delta request
        op(1, 16'h0123, 1, 5'd4, 2'd0, 16'h0123, 0, 0, 0, 0);

        // Reset during the second ripple cycle abandons the operation silently.
        op(1, 16'h0999, 0, 5'd0, 2'd0, 16'h0999, 0, 0, 0, 0);
        @(negedge clk);
        in_valid = 1'b1; delta = 5'd1; pos = 2'd0;
        @(posedge clk);
        #1;
        in_valid = 1'b0;
        @(negedge clk);
        chk("ripple1_ready", int'(in_ready), 0);
        chk("ripple1_value", int'(value), 16'h0990);
        @(negedge clk);
        chk("ripple2_ready", int'(in_ready), 0);
        reset = 1'b1;
        @(posedge clk);
        #1;
        reset = 1'b0;
        @(negedge clk);
        chk("abort_value", int'(value), 0);
        chk("abort_ready", int'(in_ready), 1);
        chk("abort_done", int'(done), 0);
        repeat (4) @(negedge clk);
        chk("abort_idle_value", int'(value), 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
